// File: rtl/simulador_caixas.sv
// simulador_caixas: two-tank plant emulator with inverted-logic level sensors and sticky alarms.
// Define SIM_CONSUMO_EN to enable the periodic upper-tank consumption path.
module simulador_caixas #(
  parameter int TICK_DIV      = 25_000_000,
  parameter int CONSUMO_TICKS = 4
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       bomba,
  input  logic       valvula,
  input  logic       carregar,
  input  logic [2:0] nivel_inf_in,
  input  logic [2:0] nivel_sup_in,
  output logic [4:0] sensores_inf,
  output logic [4:0] sensores_sup,
  output logic [2:0] nivel_inf,
  output logic [2:0] nivel_sup,
  output logic       tick,
  output logic       alarme_seca,
  output logic       alarme_transbordo
);

  localparam int               DIV_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(1);
  localparam logic [2:0]       LVL_MAX  = 3'd5;

  logic [DIV_W-1:0] div_r;
  logic [2:0]       inf_r;
  logic [2:0]       sup_r;
  logic             tick_r;
  logic             seca_r;
  logic             trans_r;

  logic             step_s;
  logic             xfer_s;
  logic             fill_s;
  logic             cons_s;
  logic             cons_due_s;
  logic             seca_set_s;
  logic             trans_set_s;
  logic [2:0]       inf_nxt_s;
  logic [2:0]       sup_nxt_s;

  function automatic logic [2:0] clamp_lvl(input logic [2:0] v);
    if (v > LVL_MAX) return LVL_MAX;
    else return v;
  endfunction

  // Sensor bit i reads 0 (wet) when the level is above i.
  function automatic logic [4:0] decode_lvl(input logic [2:0] lvl);
    logic [4:0] s;
    for (int i = 0; i < 5; i++) s[i] = (lvl <= 3'(i));
    return s;
  endfunction

  assign step_s = (div_r == DIV_LAST);

`ifdef SIM_CONSUMO_EN
  localparam int                CONS_W    = (CONSUMO_TICKS > 1) ? $clog2(CONSUMO_TICKS) : 1;
  localparam logic [CONS_W-1:0] CONS_LAST = CONS_W'(CONSUMO_TICKS - 1);
  localparam logic [CONS_W-1:0] CONS_ONE  = CONS_W'(1);

  logic [CONS_W-1:0] cons_cnt_r;

  assign cons_due_s = (cons_cnt_r == CONS_LAST);

  // Counts plant steps between one-level consumption events.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cons_cnt_r <= {CONS_W{1'b0}};
    end else if (carregar) begin
      cons_cnt_r <= {CONS_W{1'b0}};
    end else if (step_s) begin
      cons_cnt_r <= cons_due_s ? {CONS_W{1'b0}} : cons_cnt_r + CONS_ONE;
    end else begin
      cons_cnt_r <= cons_cnt_r;
    end
  end
`else
  // CONSUMO_TICKS only matters when consumption is compiled in.
  assign cons_due_s = 1'b0 && (CONSUMO_TICKS > 0);
`endif

  // Next plant state from pre-step levels; the guards keep levels inside 0..5.
  always_comb begin
    xfer_s      = bomba & (inf_r != 3'd0) & (sup_r != LVL_MAX);
    fill_s      = valvula & ((inf_r != LVL_MAX) | xfer_s);
    cons_s      = cons_due_s & (sup_r != 3'd0);
    inf_nxt_s   = inf_r + {2'b00, fill_s} - {2'b00, xfer_s};
    sup_nxt_s   = sup_r + {2'b00, xfer_s} - {2'b00, cons_s};
    seca_set_s  = bomba & (inf_r == 3'd0);
    trans_set_s = (valvula & (inf_r == LVL_MAX) & ~xfer_s) | (bomba & (sup_r == LVL_MAX));
  end

  // Divider, levels, tick and sticky alarms; load has priority over a step.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      div_r   <= {DIV_W{1'b0}};
      inf_r   <= 3'd0;
      sup_r   <= 3'd0;
      tick_r  <= 1'b0;
      seca_r  <= 1'b0;
      trans_r <= 1'b0;
    end else if (carregar) begin
      div_r   <= {DIV_W{1'b0}};
      inf_r   <= clamp_lvl(nivel_inf_in);
      sup_r   <= clamp_lvl(nivel_sup_in);
      tick_r  <= 1'b0;
      seca_r  <= seca_r;
      trans_r <= trans_r;
    end else if (step_s) begin
      div_r   <= {DIV_W{1'b0}};
      inf_r   <= inf_nxt_s;
      sup_r   <= sup_nxt_s;
      tick_r  <= 1'b1;
      seca_r  <= seca_r | seca_set_s;
      trans_r <= trans_r | trans_set_s;
    end else begin
      div_r   <= div_r + DIV_ONE;
      inf_r   <= inf_r;
      sup_r   <= sup_r;
      tick_r  <= 1'b0;
      seca_r  <= seca_r;
      trans_r <= trans_r;
    end
  end

  assign sensores_inf      = decode_lvl(inf_r);
  assign sensores_sup      = decode_lvl(sup_r);
  assign nivel_inf         = inf_r;
  assign nivel_sup         = sup_r;
  assign tick              = tick_r;
  assign alarme_seca       = seca_r;
  assign alarme_transbordo = trans_r;

endmodule

// File: tb/tb_simulador_caixas.sv
// Self-checking bench for simulador_caixas: directed table, corner sequences and a
// randomized run against an arithmetic plant model.
module tb_simulador_caixas;

  localparam int TD = 4;
  localparam int CT = 3;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       bomba;
  logic       valvula;
  logic       carregar;
  logic [2:0] nivel_inf_in;
  logic [2:0] nivel_sup_in;
  logic [4:0] sensores_inf;
  logic [4:0] sensores_sup;
  logic [2:0] nivel_inf;
  logic [2:0] nivel_sup;
  logic       tick;
  logic       alarme_seca;
  logic       alarme_transbordo;

  always #5 clk = ~clk;

  simulador_caixas #(.TICK_DIV(TD), .CONSUMO_TICKS(CT)) dut (
    .clk(clk), .reset_n(reset_n), .bomba(bomba), .valvula(valvula), .carregar(carregar),
    .nivel_inf_in(nivel_inf_in), .nivel_sup_in(nivel_sup_in),
    .sensores_inf(sensores_inf), .sensores_sup(sensores_sup),
    .nivel_inf(nivel_inf), .nivel_sup(nivel_sup), .tick(tick),
    .alarme_seca(alarme_seca), .alarme_transbordo(alarme_transbordo)
  );

  int checks = 0;
  int failures = 0;

  // Plant model: levels as integers, timing from edges elapsed since the last reset/load.
  int m_inf = 0, m_sup = 0, m_edges = 0, m_steps = 0;
  bit m_tick = 0, m_seca = 0, m_trans = 0;

  typedef struct {
    int inf0, sup0, b, v, ticks;
    int exp_inf, exp_sup, exp_seca, exp_trans;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, expv, $time);
    end
  endtask

  function automatic logic [4:0] sens(input int lvl);
    logic [4:0] s;
    for (int i = 0; i < 5; i++) s[i] = (lvl > i) ? 1'b0 : 1'b1;
    return s;
  endfunction

  function automatic int min5(input int x);
    return (x > 5) ? 5 : x;
  endfunction

  task automatic model_update();
    bit xfer, fill, cons, due;
    if (!reset_n) begin
      m_inf = 0; m_sup = 0; m_edges = 0; m_steps = 0;
      m_tick = 0; m_seca = 0; m_trans = 0;
    end else if (carregar) begin
      m_inf = min5(int'(nivel_inf_in)); m_sup = min5(int'(nivel_sup_in));
      m_edges = 0; m_steps = 0; m_tick = 0;
    end else begin
      m_edges++;
      if (m_edges % TD == 0) begin
        m_tick = 1;
        m_steps++;
`ifdef SIM_CONSUMO_EN
        due = (m_steps % CT == 0);
`else
        due = 0;
`endif
        xfer = bomba && m_inf > 0 && m_sup < 5;
        fill = valvula && (m_inf < 5 || xfer);
        cons = due && m_sup > 0;
        if (bomba && m_inf == 0) m_seca = 1;
        if ((valvula && m_inf == 5 && !xfer) || (bomba && m_sup == 5)) m_trans = 1;
        m_inf = m_inf + int'(fill) - int'(xfer);
        m_sup = m_sup + int'(xfer) - int'(cons);
      end else begin
        m_tick = 0;
      end
    end
  endtask

  // One clock: model follows the edge, DUT is compared on the falling edge.
  task automatic cyc();
    @(posedge clk);
    model_update();
    @(negedge clk);
    chk("mdl_inf", nivel_inf, m_inf);
    chk("mdl_sup", nivel_sup, m_sup);
    chk("mdl_sens_inf", sensores_inf, sens(m_inf));
    chk("mdl_sens_sup", sensores_sup, sens(m_sup));
    chk("mdl_tick", tick, m_tick);
    chk("mdl_seca", alarme_seca, m_seca);
    chk("mdl_trans", alarme_transbordo, m_trans);
  endtask

  task automatic do_reset();
    reset_n = 1'b0; carregar = 1'b0; bomba = 1'b0; valvula = 1'b0;
    cyc();
    reset_n = 1'b1;
  endtask

  task automatic wait_tick(input string name);
    for (int k = 1; k < TD; k++) begin
      cyc();
      chk({name, "_notick"}, tick, 1'b0);
    end
    cyc();
    chk({name, "_tick"}, tick, 1'b1);
  endtask

  task automatic load(input int li, input int ls);
    carregar = 1'b1; nivel_inf_in = 3'(li); nivel_sup_in = 3'(ls);
    cyc();
    carregar = 1'b0;
  endtask

  vec_t vecs[8];

  initial begin
    reset_n = 1'b0; carregar = 1'b1; bomba = 1'b0; valvula = 1'b0;
    nivel_inf_in = 3'd5; nivel_sup_in = 3'd5;

    // Reset beats carregar; first tick on the 4th edge after release.
    cyc(); cyc();
    chk("rst_sens_inf", sensores_inf, 5'b11111);
    chk("rst_sens_sup", sensores_sup, 5'b11111);
    chk("rst_inf", nivel_inf, 3'd0);
    chk("rst_sup", nivel_sup, 3'd0);
    chk("rst_tick", tick, 1'b0);
    chk("rst_seca", alarme_seca, 1'b0);
    chk("rst_trans", alarme_transbordo, 1'b0);
    reset_n = 1'b1; carregar = 1'b0;
    wait_tick("rst_first");

    // Fill from empty up to overflow.
    do_reset();
    valvula = 1'b1;
    for (int t = 1; t <= 5; t++) begin
      wait_tick("fill");
      chk("fill_inf", nivel_inf, t);
    end
    chk("fill_sens5", sensores_inf, 5'b00000);
    chk("fill_trans5", alarme_transbordo, 1'b0);
    wait_tick("fill6");
    chk("fill_trans6", alarme_transbordo, 1'b1);
    chk("fill_inf6", nivel_inf, 3'd5);

`ifndef SIM_CONSUMO_EN
    // Full transfer, then dry-run and overflow together.
    do_reset();
    bomba = 1'b1;
    load(5, 0);
    for (int t = 1; t <= 5; t++) begin
      wait_tick("xfer");
      chk("xfer_inf", nivel_inf, 5 - t);
      chk("xfer_sup", nivel_sup, t);
    end
    wait_tick("xfer6");
    chk("xfer_seca", alarme_seca, 1'b1);
    chk("xfer_trans", alarme_transbordo, 1'b1);
    chk("xfer_inf6", nivel_inf, 3'd0);
    chk("xfer_sup6", nivel_sup, 3'd5);
`endif

    // Consumption: one level every CT ticks down to empty.
    do_reset();
    load(0, 3);
    for (int t = 1; t <= 12; t++) begin
      int e;
`ifdef SIM_CONSUMO_EN
      e = (3 - t / CT < 0) ? 0 : 3 - t / CT;
`else
      e = 3;
`endif
      wait_tick("cons");
      chk("cons_sup", nivel_sup, e);
    end
    chk("cons_seca", alarme_seca, 1'b0);
    chk("cons_trans", alarme_transbordo, 1'b0);

    // Directed table (at most 2 ticks, so consumption never falls due).
    vecs[0] = '{0, 0, 0, 1, 2, 2, 0, 0, 0};
    vecs[1] = '{5, 0, 1, 0, 2, 3, 2, 0, 0};
    vecs[2] = '{5, 2, 1, 1, 1, 5, 3, 0, 0};
    vecs[3] = '{0, 3, 1, 0, 1, 0, 3, 1, 0};
    vecs[4] = '{1, 5, 1, 0, 2, 1, 5, 0, 1};
    vecs[5] = '{5, 1, 0, 1, 1, 5, 1, 0, 1};
    vecs[6] = '{7, 6, 0, 0, 1, 5, 5, 0, 0};
    vecs[7] = '{3, 4, 1, 1, 2, 4, 5, 0, 1};
    for (int i = 0; i < 8; i++) begin
      do_reset();
      bomba = 1'(vecs[i].b); valvula = 1'(vecs[i].v);
      load(vecs[i].inf0, vecs[i].sup0);
      for (int t = 0; t < vecs[i].ticks; t++) wait_tick("vec");
      chk($sformatf("vec%0d_inf", i), nivel_inf, vecs[i].exp_inf);
      chk($sformatf("vec%0d_sup", i), nivel_sup, vecs[i].exp_sup);
      chk($sformatf("vec%0d_seca", i), alarme_seca, vecs[i].exp_seca);
      chk($sformatf("vec%0d_trans", i), alarme_transbordo, vecs[i].exp_trans);
    end

    // Load on the step edge wins; tick realigns to the load edge.
    do_reset();
    valvula = 1'b1;
    wait_tick("col_pre");
    cyc(); cyc(); cyc();
    load(2, 0);
    chk("col_inf", nivel_inf, 3'd2);
    chk("col_tick", tick, 1'b0);
    wait_tick("col_next");
    chk("col_inf_after", nivel_inf, 3'd3);
    cyc();
    reset_n = 1'b0;
    cyc();
    chk("mrst_inf", nivel_inf, 3'd0);
    chk("mrst_sens", sensores_inf, 5'b11111);
    chk("mrst_tick", tick, 1'b0);
    chk("mrst_trans", alarme_transbordo, 1'b0);
    reset_n = 1'b1;

    // Randomized run against the model.
    for (int n = 0; n < 3000; n++) begin
      reset_n      = ($urandom_range(0, 99) != 0);
      carregar     = ($urandom_range(0, 29) == 0);
      bomba        = 1'($urandom_range(0, 1));
      valvula      = 1'($urandom_range(0, 1));
      nivel_inf_in = 3'($urandom_range(0, 7));
      nivel_sup_in = 3'($urandom_range(0, 7));
      cyc();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
